// File: rtl/ysyx22041405_mem_arbiter_if.sv
// Request/response bus shared by the fetch, load/store and memory sides of the arbiter.
// The requester drives the request fields. The responder drives ready and the response.
interface ysyx22041405_mem_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic               req_valid;
    logic               req_ready;
    logic [WIDTH-1:0]   addr;
    logic               we;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH/8-1:0] wmask;
    logic               resp_valid;
    logic [WIDTH-1:0]   rdata;

    modport master (
        output req_valid, addr, we, wdata, wmask,
        input  req_ready, resp_valid, rdata
    );

    modport slave (
        input  req_valid, addr, we, wdata, wmask,
        output req_ready, resp_valid, rdata
    );
endinterface

// File: rtl/ysyx22041405_mem_arbiter.sv
// Arbitrates the IFU and LSU onto a single memory port with one outstanding transaction.
// LSU has priority. A starvation counter forces a fetch grant after STARVE_MAX LSU wins.
module ysyx22041405_mem_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    ysyx22041405_mem_arbiter_if.slave         ifu,
    ysyx22041405_mem_arbiter_if.slave         lsu,
    ysyx22041405_mem_arbiter_if.master        mem,
    output logic                              busy
);
    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e             state_q, state_d;
    logic               owner_ls_q;
    logic [CntW-1:0]    starve_q;
    logic [WIDTH-1:0]   addr_q;
    logic               we_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [WIDTH/8-1:0] wmask_q;

    logic force_if, grant_if, grant_ls, resp_fire;

    // Fetch requests never carry write data.
    logic unused_ifu_fields;
    assign unused_ifu_fields = ^{ifu.we, ifu.wdata, ifu.wmask};

    always_comb begin
        force_if = (starve_q == CntW'(STARVE_MAX));
        grant_if = (state_q == StIdle) && ifu.req_valid && (force_if || !lsu.req_valid);
        grant_ls = (state_q == StIdle) && lsu.req_valid && !(force_if && ifu.req_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_if || grant_ls) state_d = StReq;
            StReq:   if (mem.req_ready)        state_d = StWait;
            StWait:  if (mem.resp_valid)       state_d = StIdle;
            default:                           state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_ls_q <= 1'b0;
            starve_q   <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else if (grant_if) begin
            owner_ls_q <= 1'b0;
            starve_q   <= '0;
            addr_q     <= ifu.addr;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else if (grant_ls) begin
            owner_ls_q <= 1'b1;
            addr_q     <= lsu.addr;
            we_q       <= lsu.we;
            wdata_q    <= lsu.wdata;
            wmask_q    <= lsu.wmask;
            // Count only LSU wins that actually made a waiting fetch wait longer.
            if (!ifu.req_valid) begin
                starve_q <= '0;
            end else if (!force_if) begin
                starve_q <= starve_q + CntW'(1);
            end
        end
    end

    always_comb begin
        resp_fire      = (state_q == StWait) && mem.resp_valid;
        ifu.req_ready  = grant_if;
        lsu.req_ready  = grant_ls;
        ifu.resp_valid = resp_fire && !owner_ls_q;
        lsu.resp_valid = resp_fire && owner_ls_q;
        ifu.rdata      = ifu.resp_valid ? mem.rdata : '0;
        lsu.rdata      = lsu.resp_valid ? mem.rdata : '0;
        mem.req_valid  = (state_q == StReq);
        mem.addr       = addr_q;
        mem.we         = we_q;
        mem.wdata      = wdata_q;
        mem.wmask      = wmask_q;
        busy           = (state_q != StIdle);
    end
endmodule

// File: doc/ysyx22041405_mem_arbiter.md
# ysyx22041405_mem_arbiter

Two-requester memory arbiter between the instruction-fetch unit and the load/store unit and a single shared data/instruction memory port. It accepts one request at a time with a valid/ready handshake, forwards it to the memory port, and routes the memory response back to the requester that issued it. Load/store has priority, and a starvation counter guarantees fetch progress. It sits between IFU/LSU and the memory/bus interface of the pipeline.

## Interface
- WIDTH, 32, address and data width; byte-mask width is WIDTH/8
- STARVE_MAX, 4, consecutive LS grants allowed while IF is waiting before IF is forced
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle when high together with valid
- if_addr  in  WIDTH  fetch address
- if_resp_valid  out  1  one-cycle fetch response strobe
- if_rdata  out  WIDTH  fetch data, valid with if_resp_valid
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store request accepted
- ls_addr  in  WIDTH  load/store address
- ls_we  in  1  1 = store, 0 = load
- ls_wdata  in  WIDTH  store data
- ls_wmask  in  WIDTH/8  store byte enables
- ls_resp_valid  out  1  one-cycle response strobe (load data or store ack)
- ls_rdata  out  WIDTH  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr / mem_we / mem_wdata / mem_wmask  out  WIDTH/1/WIDTH/WIDTH/8  registered request fields
- mem_resp_valid  in  1  memory response strobe
- mem_rdata  in  WIDTH  memory read data
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, REQ, WAIT. One outstanding transaction; owner register (IF/LS) is held from accept until response.
- IDLE: grant selection: if force_if (starve_cnt == STARVE_MAX) and if_req_valid -> IF; else ls_req_valid -> LS; else if_req_valid -> IF; else no grant.
- ls_req_ready = IDLE && grant is LS; if_req_ready = IDLE && grant is IF. At most one ready is high per cycle.
- On accept: latch addr, we, wdata, wmask (IF: we=0, wdata=0, wmask=0) and owner; go to REQ.
- REQ: mem_req_valid=1 with latched fields held stable; on mem_req_ready -> WAIT.
- WAIT: on mem_resp_valid, assert owner's resp_valid for exactly that cycle, with rdata = mem_rdata (combinational pass-through); next state IDLE. Stores also receive ls_resp_valid (ack); ls_rdata is don't-care.
- Non-owner resp_valid is always 0; mem_resp_valid in IDLE or REQ is ignored.
- starve_cnt: on LS accept while if_req_valid is high, increment (saturating at STARVE_MAX); on IF accept, clear; on LS accept with IF not requesting, clear.

## Timing
- Reset: state=IDLE, owner=IF, starve_cnt=0, all mem_* registers 0; after reset every output is 0 except that if_req_ready/ls_req_ready follow the grant rule combinationally from cycle 1.
- Accept at cycle T -> mem_req_valid from T+1. If mem_req_ready is high at T+1 -> WAIT at T+2. The earliest resp_valid is at T+2 (mem_resp_valid at T+2). The earliest next accept is at T+3.
- Requester valid/ready: the requester may drop valid before ready; nothing is latched without the handshake.
- Simultaneous IF and LS valid in IDLE: LS wins unless force_if.
- rst asserted in REQ or WAIT: next cycle IDLE, the transaction is abandoned with no resp_valid, and a late mem_resp_valid is ignored.
- mem_req_ready held low: stay in REQ indefinitely with stable fields; no new accepts.

## Test plan
- Single fetch: if_addr=0x80000000, mem_req_ready=1, mem_resp_valid at T+2 with rdata=0x00100073 -> if_req_ready at T, mem_addr=0x80000000 at T+1, if_resp_valid=1 with if_rdata=0x00100073 at T+2 only.
- Store: ls_we=1, ls_addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF -> mem fields match at T+1; ls_resp_valid at response; if_resp_valid stays 0.
- Contention: IF and LS both valid in IDLE -> LS accepted first; IF accepted on the next IDLE cycle.
- Starvation: LS valid continuously and IF valid -> after 4 LS grants, the 5th grant goes to IF, then starve_cnt returns to 0.
- Backpressure: mem_req_ready low for 5 cycles -> mem_req_valid and fields are stable, both readys are 0, and busy=1.
- Reset mid-WAIT: rst for 1 cycle, then mem_resp_valid -> no resp_valid, state IDLE, and the next request proceeds normally.
